// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter
//   Shares one SRAM-like master port (towards the AXI bridge) between the
//   IF-stage inst_sram port and the MEM-stage data_sram port. Address requests
//   are arbitrated every cycle with no lock. Data normally has priority. Inst
//   is forced through after STARVE_MAX consecutive losses to accepted data
//   requests. Accepted transactions are tagged in an in-order FIFO, and each
//   bridge response is routed to the owner of the FIFO head.
//
// Ports
//   clk, reset              clock, synchronous active-high reset
//   inst_sram_*             IF request/response port (addr_ok_addr echoes the
//                           address accepted this cycle, else the last one)
//   data_sram_*             MEM request/response port
//   m_*                     muxed request to the bridge, bridge handshake and
//                           in-order response
//   arb_err                 sticky: bridge response seen while no transaction
//                           was outstanding
module sram_like_arbiter #(
  parameter int OUTSTANDING = 4,
  parameter int STARVE_MAX  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_sram_en,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wen,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic [31:0] inst_sram_addr_ok_addr,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_en,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  output logic        m_en,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [3:0]  m_wen,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  input  logic [31:0] m_rdata,
  output logic        arb_err
);

  localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(OUTSTANDING);
  localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_MAX);

  // Saturating increment of the starvation counter.
  function automatic logic [STV_W-1:0] sat_inc(input logic [STV_W-1:0] v);
    return (v == STV_MAX) ? v : v + 1'b1;
  endfunction

  logic [OUTSTANDING-1:0] tag_q;
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [CNT_W-1:0]       count;
  logic [STV_W-1:0]       starve_cnt;
  logic [31:0]            last_inst_addr;

  logic full, empty, force_i, gnt_d, gnt_i, push, pop, head_tag;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign force_i = inst_sram_en & (starve_cnt == STV_MAX);
  // A full FIFO blocks all grants, even in a cycle that also pops.
  assign gnt_d   = ~full & data_sram_en & ~force_i;
  assign gnt_i   = ~full & inst_sram_en & ~gnt_d;

  always_comb begin
    m_en    = gnt_d | gnt_i;
    m_wr    = 1'b0;
    m_size  = '0;
    m_wen   = '0;
    m_addr  = '0;
    m_wdata = '0;
    if (gnt_d) begin
      m_wr    = data_sram_wr;
      m_size  = data_sram_size;
      m_wen   = data_sram_wen;
      m_addr  = data_sram_addr;
      m_wdata = data_sram_wdata;
    end else if (gnt_i) begin
      m_wr    = inst_sram_wr;
      m_size  = inst_sram_size;
      m_wen   = inst_sram_wen;
      m_addr  = inst_sram_addr;
      m_wdata = inst_sram_wdata;
    end
  end

  assign inst_sram_addr_ok = gnt_i & m_addr_ok;
  assign data_sram_addr_ok = gnt_d & m_addr_ok;
  assign inst_sram_addr_ok_addr = inst_sram_addr_ok ? inst_sram_addr : last_inst_addr;

  assign push     = m_en & m_addr_ok;
  assign pop      = m_data_ok & ~empty;
  assign head_tag = tag_q[rd_ptr];

  // Responses arriving with nothing outstanding are dropped here.
  assign inst_sram_data_ok = pop & ~head_tag;
  assign data_sram_data_ok = pop & head_tag;
  assign inst_sram_rdata   = m_rdata;
  assign data_sram_rdata   = m_rdata;

  // Tag storage: 1 = data, 0 = inst. Contents need no reset; validity is count.
  always_ff @(posedge clk) begin
    if (push) tag_q[wr_ptr] <= gnt_d;
  end

  // Control state: FIFO pointers/count, starvation counter, echo register, error.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      starve_cnt     <= '0;
      last_inst_addr <= '0;
      arb_err        <= 1'b0;
    end else begin
      // Pointers wrap naturally because OUTSTANDING is a power of two.
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (~inst_sram_en | inst_sram_addr_ok) starve_cnt <= '0;
      else if (gnt_d & m_addr_ok)            starve_cnt <= sat_inc(starve_cnt);
      if (inst_sram_addr_ok) last_inst_addr <= inst_sram_addr;
      if (m_data_ok & empty) arb_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Testbench for sram_like_arbiter: directed stimulus, an owner-queue reference
// model compared against the DUT every cycle, plus literal expectations.
module tb_sram_like_arbiter;
  localparam int OUT  = 4;
  localparam int SMAX = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        inst_sram_en = 0, inst_sram_wr = 0;
  logic [1:0]  inst_sram_size = 0;
  logic [3:0]  inst_sram_wen = 0;
  logic [31:0] inst_sram_addr = 0, inst_sram_wdata = 0;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_addr_ok_addr, inst_sram_rdata;
  logic        data_sram_en = 0, data_sram_wr = 0;
  logic [1:0]  data_sram_size = 0;
  logic [3:0]  data_sram_wen = 0;
  logic [31:0] data_sram_addr = 0, data_sram_wdata = 0;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        m_en, m_wr;
  logic [1:0]  m_size;
  logic [3:0]  m_wen;
  logic [31:0] m_addr, m_wdata;
  logic        m_addr_ok = 0, m_data_ok = 0;
  logic [31:0] m_rdata = 0;
  logic        arb_err;

  sram_like_arbiter #(.OUTSTANDING(OUT), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset(reset),
    .inst_sram_en(inst_sram_en), .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size), .inst_sram_wen(inst_sram_wen),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_addr_ok_addr(inst_sram_addr_ok_addr),
    .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata),
    .data_sram_en(data_sram_en), .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size), .data_sram_wen(data_sram_wen),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata),
    .m_en(m_en), .m_wr(m_wr), .m_size(m_size), .m_wen(m_wen),
    .m_addr(m_addr), .m_wdata(m_wdata),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
    .arb_err(arb_err)
  );

  int checks = 0;
  int errors = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state: owner queue (1 = data), starvation, sticky error, echo.
  bit          mq[$];
  int          md_starve = 0;
  bit          md_err = 0;
  logic [31:0] md_last = 0;
  bit          armed = 0;

  // Observation logs from DUT outputs (1 = data, 0 = inst).
  bit          acc_log[$];
  bit          rsp_log[$];
  logic [31:0] rdat_log[$];
  int          both_cnt = 0;

  always @(negedge clk) begin : compare
    bit full, frc, gd, gi, acc, pop, own;
    logic e_wr;
    logic [1:0] e_size;
    logic [3:0] e_wen;
    logic [31:0] e_addr, e_wdata;
    if (!armed) begin
      if (reset) armed = 1;
    end else begin
      full = (mq.size() == OUT);
      frc  = inst_sram_en && (md_starve == SMAX);
      gd   = !full && data_sram_en && !frc;
      gi   = !full && inst_sram_en && !gd;
      acc  = (gd || gi) && m_addr_ok;
      pop  = m_data_ok && (mq.size() > 0);
      own  = pop ? mq[0] : 1'b0;
      e_wr = 0; e_size = 0; e_wen = 0; e_addr = 0; e_wdata = 0;
      if (gd) begin
        e_wr = data_sram_wr; e_size = data_sram_size; e_wen = data_sram_wen;
        e_addr = data_sram_addr; e_wdata = data_sram_wdata;
      end else if (gi) begin
        e_wr = inst_sram_wr; e_size = inst_sram_size; e_wen = inst_sram_wen;
        e_addr = inst_sram_addr; e_wdata = inst_sram_wdata;
      end
      chk("m_en", m_en, gd || gi);
      chk("m_wr", m_wr, e_wr);
      chk("m_size", m_size, e_size);
      chk("m_wen", m_wen, e_wen);
      chk("m_addr", m_addr, e_addr);
      chk("m_wdata", m_wdata, e_wdata);
      chk("inst_addr_ok", inst_sram_addr_ok, gi && m_addr_ok);
      chk("data_addr_ok", data_sram_addr_ok, gd && m_addr_ok);
      chk("addr_ok_addr", inst_sram_addr_ok_addr, (gi && m_addr_ok) ? inst_sram_addr : md_last);
      chk("inst_data_ok", inst_sram_data_ok, pop && !own);
      chk("data_data_ok", data_sram_data_ok, pop && own);
      chk("inst_rdata", inst_sram_rdata, m_rdata);
      chk("data_rdata", data_sram_rdata, m_rdata);
      chk("arb_err", arb_err, md_err);
      if (inst_sram_addr_ok) acc_log.push_back(1'b0);
      if (data_sram_addr_ok) acc_log.push_back(1'b1);
      if (inst_sram_data_ok) begin rsp_log.push_back(1'b0); rdat_log.push_back(inst_sram_rdata); end
      if (data_sram_data_ok) begin rsp_log.push_back(1'b1); rdat_log.push_back(data_sram_rdata); end
      if (inst_sram_data_ok && data_sram_data_ok) both_cnt++;
      if (reset) begin
        mq.delete(); md_starve = 0; md_err = 0; md_last = 0;
      end else begin
        if (pop) void'(mq.pop_front());
        else if (m_data_ok) md_err = 1;
        if (acc) mq.push_back(gd);
        if (!inst_sram_en || (gi && m_addr_ok)) md_starve = 0;
        else if (gd && m_addr_ok && md_starve < SMAX) md_starve++;
        if (gi && m_addr_ok) md_last = inst_sram_addr;
      end
    end
  end

  // Auto bridge: answers each accepted request lat cycles later, in order.
  bit auto_br = 0;
  int lat = 2;
  int pend[$];
  int rsp_n = 0;
  always begin
    @(negedge clk);
    if (auto_br && m_en && m_addr_ok) pend.push_back(cyc + lat);
    @(posedge clk);
    #1;
    if (auto_br) begin
      if (pend.size() > 0 && pend[0] <= cyc) begin
        m_data_ok = 1; m_rdata = {16'hBEEF, 16'(rsp_n)}; rsp_n++;
        void'(pend.pop_front());
      end else begin
        m_data_ok = 0; m_rdata = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    int nd;
    repeat (3) step();
    reset = 0;
    mid();
    chk("rst_arb_err", arb_err, 0);
    chk("rst_addr_ok_addr", inst_sram_addr_ok_addr, 0);
    chk("rst_m_en", m_en, 0);

    // 1: inst-only reads, including a retarget while addr_ok is withheld
    auto_br = 1; m_addr_ok = 1;
    step(); inst_sram_en = 1; inst_sram_size = 2; inst_sram_addr = 32'h100;
    mid(); chk("t1_addr_ok", inst_sram_addr_ok, 1); chk("t1_echo0", inst_sram_addr_ok_addr, 32'h100);
    step(); inst_sram_addr = 32'h104;
    step(); inst_sram_addr = 32'h108;
    step(); m_addr_ok = 0; inst_sram_addr = 32'h300;
    mid(); chk("t1_no_ok", inst_sram_addr_ok, 0); chk("t1_echo_hold", inst_sram_addr_ok_addr, 32'h108);
    step(); m_addr_ok = 1; inst_sram_addr = 32'h304;
    mid(); chk("t1_echo_retarget", inst_sram_addr_ok_addr, 32'h304);
    step(); inst_sram_en = 0;
    mid(); chk("t1_echo_idle", inst_sram_addr_ok_addr, 32'h304);
    repeat (4) step();
    chk("t1_rsp_cnt", rsp_log.size(), 4);
    nd = 0; foreach (rsp_log[i]) nd += rsp_log[i];
    chk("t1_rsp_all_inst", nd, 0);
    chk("t1_rdata0", rdat_log[0], 32'hBEEF_0000);
    chk("t1_rdata3", rdat_log[3], 32'hBEEF_0003);

    // 2: starvation - data held 20 cycles alongside inst
    acc_log.delete();
    step();
    data_sram_en = 1; data_sram_wr = 1; data_sram_size = 2; data_sram_wen = 4'hF;
    data_sram_addr = 32'h2000; data_sram_wdata = 32'h1234_5678;
    inst_sram_en = 1; inst_sram_addr = 32'h400;
    repeat (19) step();
    step(); data_sram_en = 0; inst_sram_en = 0; data_sram_wr = 0; data_sram_wen = 0;
    repeat (4) step();
    chk("t2_acc_cnt", acc_log.size(), 20);
    nd = 0; for (int i = 0; i < 8; i++) nd += acc_log[i];
    chk("t2_first8_data", nd, 8);
    chk("t2_9th_inst", acc_log[8], 0);
    chk("t2_10th_data", acc_log[9], 1);
    chk("t2_18th_inst", acc_log[17], 0);

    // 3: interleaved D,I,D,I then back-to-back responses
    auto_br = 0; m_data_ok = 0; m_rdata = 0;
    rsp_log.delete(); both_cnt = 0;
    step(); data_sram_en = 1; data_sram_addr = 32'h500;
    step(); data_sram_en = 0; inst_sram_en = 1; inst_sram_addr = 32'h600;
    step(); inst_sram_en = 0; data_sram_en = 1; data_sram_addr = 32'h504;
    step(); data_sram_en = 0; inst_sram_en = 1; inst_sram_addr = 32'h604;
    step(); inst_sram_en = 0;
    step(); m_data_ok = 1; m_rdata = 32'h11;
    step(); m_rdata = 32'h22;
    step(); m_rdata = 32'h33;
    step(); m_rdata = 32'h44;
    step(); m_data_ok = 0; m_rdata = 0;
    mid();
    chk("t3_rsp_cnt", rsp_log.size(), 4);
    chk("t3_rsp0_D", rsp_log[0], 1);
    chk("t3_rsp1_I", rsp_log[1], 0);
    chk("t3_rsp2_D", rsp_log[2], 1);
    chk("t3_rsp3_I", rsp_log[3], 0);
    chk("t3_never_both", both_cnt, 0);

    // 4: fill to OUTSTANDING, grant blocked while full including pop cycle
    step(); data_sram_en = 1; data_sram_addr = 32'h700;
    repeat (3) step();
    step();
    mid(); chk("t4_full_m_en", m_en, 0);
    step(); m_data_ok = 1;
    mid(); chk("t4_pop_m_en", m_en, 0); chk("t4_pop_data_ok", data_sram_data_ok, 1);
    step(); m_data_ok = 0;
    mid(); chk("t4_resume_m_en", m_en, 1); chk("t4_resume_ok", data_sram_addr_ok, 1);
    step(); data_sram_en = 0; m_data_ok = 1;
    repeat (3) step();
    step(); m_data_ok = 0;

    // 5: simultaneous push/pop at count 2 with write pointer wrapping 3->0
    step(); reset = 1;
    step(); reset = 0;
    rsp_log.delete();
    step(); inst_sram_en = 1; inst_sram_addr = 32'h800;
    step(); inst_sram_en = 0; data_sram_en = 1; data_sram_addr = 32'h900;
    step(); data_sram_en = 0; inst_sram_en = 1; inst_sram_addr = 32'h804;
    step(); inst_sram_en = 0; m_data_ok = 1;
    step(); data_sram_en = 1; data_sram_addr = 32'h904;
    mid(); chk("t5_simul_push", data_sram_addr_ok, 1); chk("t5_simul_pop_D", data_sram_data_ok, 1);
    step(); data_sram_en = 0;
    step();
    step(); m_data_ok = 0;
    mid();
    chk("t5_rsp_cnt", rsp_log.size(), 4);
    chk("t5_rsp0", rsp_log[0], 0);
    chk("t5_rsp1", rsp_log[1], 1);
    chk("t5_rsp2", rsp_log[2], 0);
    chk("t5_rsp3", rsp_log[3], 1);
    chk("t5_no_err", arb_err, 0);

    // 6: response with empty FIFO sets sticky error; reset clears it
    step(); m_data_ok = 1; m_rdata = 32'hDEAD;
    mid(); chk("t6_no_inst_ok", inst_sram_data_ok, 0); chk("t6_no_data_ok", data_sram_data_ok, 0);
    step(); m_data_ok = 0; m_rdata = 0;
    mid(); chk("t6_err_set", arb_err, 1);
    repeat (3) step();
    mid(); chk("t6_err_held", arb_err, 1);
    step(); reset = 1;
    step(); reset = 0;
    mid(); chk("t6_err_cleared", arb_err, 0);
    step(); inst_sram_en = 1; inst_sram_addr = 32'hA00;
    step(); inst_sram_en = 0;
    step(); reset = 1;
    step(); reset = 0;
    step(); m_data_ok = 1;
    mid(); chk("t6_stale_dropped", inst_sram_data_ok, 0);
    step(); m_data_ok = 0;
    mid(); chk("t6_stale_err", arb_err, 1);

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
